// File: rtl/wb_trace_pkg.sv
// Record layout shared by the writeback trace FIFO and its storage.
// Packs {pc, ena, reg, value} into one REC_W-bit word, pc in the top bits.
package wb_trace_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned VAL_W = 32;
    localparam int unsigned REC_W = PC_W + 1 + REG_W + VAL_W;

    localparam int unsigned VAL_LSB = 0;
    localparam int unsigned REG_LSB = VAL_LSB + VAL_W;
    localparam int unsigned ENA_LSB = REG_LSB + REG_W;
    localparam int unsigned PC_LSB  = ENA_LSB + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             ena;
        logic [REG_W-1:0] rd;
        logic [VAL_W-1:0] value;
    } wb_rec_t;

    function automatic logic [REC_W-1:0] rec_pack(wb_rec_t rec);
        logic [REC_W-1:0] word;
        word                     = '0;
        word[PC_LSB +: PC_W]     = rec.pc;
        word[ENA_LSB]            = rec.ena;
        word[REG_LSB +: REG_W]   = rec.rd;
        word[VAL_LSB +: VAL_W]   = rec.value;
        return word;
    endfunction

    function automatic wb_rec_t rec_unpack(logic [REC_W-1:0] word);
        wb_rec_t rec;
        rec.pc    = word[PC_LSB +: PC_W];
        rec.ena   = word[ENA_LSB];
        rec.rd    = word[REG_LSB +: REG_W];
        rec.value = word[VAL_LSB +: VAL_W];
        return rec;
    endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// Trace record storage: DEPTH x WIDTH, one synchronous write port, one async read port.
// Storage carries no reset; emptiness is tracked by the FIFO pointers and count.
module wb_trace_ram
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = REC_W
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture FIFO with first-word-fall-through drain and drop accounting.
// Define WB_TRACE_FILTER_EN to store only register-writing instructions (wb_ena, reg != x0).
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DCW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_have_inst,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic              wb_ena,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [VAL_W-1:0]  wb_value,
    input  logic              clr_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_ena,
    output logic [REG_W-1:0]  out_reg,
    output logic [VAL_W-1:0]  out_value,
    output logic [AW:0]       count_o,
    output logic              overflow_o,
    output logic [DCW-1:0]    drop_cnt_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;

    logic             capture;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [REC_W-1:0] wr_word;
    logic [REC_W-1:0] rd_word;
    wb_rec_t          wr_rec;
    wb_rec_t          head;

`ifdef WB_TRACE_FILTER_EN
    assign capture = wb_have_inst & wb_ena & (wb_reg != '0);
`else
    assign capture = wb_have_inst;
`endif

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign push_ok   = capture & (~full | pop);
    assign drop      = capture & full & ~pop;

    always_comb begin
        wr_rec.pc    = wb_pc;
        wr_rec.ena   = wb_ena;
        wr_rec.rd    = wb_reg;
        wr_rec.value = wb_value;
        wr_word      = rec_pack(wr_rec);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear takes priority; a drop coinciding with clear is not recorded.
        if (clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    wb_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (REC_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    // Head fields are forced to zero while empty so reset and idle outputs are defined.
    always_comb begin
        head      = rec_unpack(rd_word);
        out_pc    = '0;
        out_ena   = 1'b0;
        out_reg   = '0;
        out_value = '0;
        if (out_valid) begin
            out_pc    = head.pc;
            out_ena   = head.ena;
            out_reg   = head.rd;
            out_value = head.value;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        wb_have_inst;
    logic [31:0] wb_pc;
    logic        wb_ena;
    logic [4:0]  wb_reg;
    logic [31:0] wb_value;
    logic        clr_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_ena;
    logic [4:0]  out_reg;
    logic [31:0] out_value;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    wb_trace_fifo #(
        .DEPTH (16),
        .AW    (4),
        .DCW   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_have_inst (wb_have_inst),
        .wb_pc        (wb_pc),
        .wb_ena       (wb_ena),
        .wb_reg       (wb_reg),
        .wb_value     (wb_value),
        .clr_i        (clr_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ena      (out_ena),
        .out_reg      (out_reg),
        .out_value    (out_value),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rg;
        logic [31:0] val;
    } rec_t;

    typedef struct {
        logic        have;
        logic [31:0] pc;
        logic        rdy;
        logic        exp_valid;
        int          exp_count;
        logic [31:0] exp_pc;
    } vec_t;

    rec_t        mq[$];
    logic [31:0] sink[$];
    logic        m_ovf;
    int          m_drop;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic qualifies(logic have, logic ena, logic [4:0] rg);
`ifdef WB_TRACE_FILTER_EN
        return have && ena && (rg != 5'd0);
`else
        return have;
`endif
    endfunction

    task automatic model_check();
        chk("valid", 128'(out_valid), 128'(mq.size() != 0));
        chk("count", 128'(count_o), 128'(mq.size()));
        chk("overflow", 128'(overflow_o), 128'(m_ovf));
        chk("drop_cnt", 128'(drop_cnt_o), 128'(m_drop));
        if (mq.size() != 0) begin
            chk("head", 128'({out_pc, out_ena, out_reg, out_value}), 128'(mq[0]));
        end
    endtask

    task automatic drive(input logic have, input logic [31:0] pc, input logic ena,
                         input logic [4:0] rg, input logic [31:0] val, input logic rdy,
                         input logic clr);
        wb_have_inst = have;
        wb_pc        = pc;
        wb_ena       = ena;
        wb_reg       = rg;
        wb_value     = val;
        out_ready    = rdy;
        clr_i        = clr;
        #1;
    endtask

    // Checks DUT against the model, then advances both by one clock.
    task automatic commit();
        int   sz;
        logic qual;
        logic pop;
        rec_t tmp;
        model_check();
        if (out_valid && out_ready) sink.push_back(out_pc);
        sz   = mq.size();
        qual = qualifies(wb_have_inst, wb_ena, wb_reg);
        pop  = (sz != 0) && out_ready;
        if (pop) tmp = mq.pop_front();
        if (qual && (sz < DEPTH || pop)) mq.push_back({wb_pc, wb_ena, wb_reg, wb_value});
        if (clr_i) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end else if (qual && sz == DEPTH && !pop) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic have, input logic [31:0] pc, input logic ena,
                        input logic [4:0] rg, input logic [31:0] val, input logic rdy,
                        input logic clr);
        drive(have, pc, ena, rg, val, rdy, clr);
        commit();
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        mq.delete();
        sink.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && mq.size() != 0; i++) begin
            step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", 128'(out_valid), 128'(0));
    endtask

    vec_t vecs[11];

    initial begin
        int pushed;
        int found;
        logic h;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        // Reset state, still in reset.
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_ovf", 128'(overflow_o), 128'(0));
        chk("rst_drop", 128'(drop_cnt_o), 128'(0));
        chk("rst_out", 128'({out_pc, out_ena, out_reg, out_value}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: expectations sampled before each clock edge.
        vecs[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 0, 32'h0};
        vecs[1]  = '{1'b1, 32'h04, 1'b1, 1'b1, 1, 32'h0};
        vecs[2]  = '{1'b1, 32'h08, 1'b1, 1'b1, 1, 32'h4};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1, 32'h8};
        vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 0, 32'h0};
        vecs[6]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1, 32'hC};
        vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 2, 32'hC};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 2, 32'hC};
        vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1, 32'h10};
        vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].have, vecs[i].pc, 1'b1, 5'd1, vecs[i].pc + 32'd1, vecs[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_count", i), 128'(count_o), 128'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), 128'(out_pc), 128'(vecs[i].exp_pc));
            end
            commit();
        end

        // Fill to full, then overflow, then push+pop while full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 5'd3, 32'(i), 1'b0, 1'b0);
        end
        chk("full_count", 128'(count_o), 128'(16));
        chk("full_ovf0", 128'(overflow_o), 128'(0));
        step(1'b1, 32'hDEAD0, 1'b1, 5'd3, 32'hBAD, 1'b0, 1'b0);
        chk("ovf_flag", 128'(overflow_o), 128'(1));
        chk("ovf_drop", 128'(drop_cnt_o), 128'(1));
        chk("ovf_count", 128'(count_o), 128'(16));
        step(1'b1, 32'h200, 1'b1, 5'd3, 32'h77, 1'b1, 1'b0);
        chk("fullpp_count", 128'(count_o), 128'(16));
        chk("fullpp_drop", 128'(drop_cnt_o), 128'(1));
        sink.delete();
        drain(40);
        chk("fullpp_n", 128'(sink.size()), 128'(16));
        if (sink.size() == 16) begin
            chk("fullpp_first", 128'(sink[0]), 128'(32'h104));
            chk("fullpp_last", 128'(sink[15]), 128'(32'h200));
        end
        found = 0;
        foreach (sink[i]) if (sink[i] == 32'hDEAD0) found++;
        chk("dropped_absent", 128'(found), 128'(0));

        // Clear coinciding with a drop, then a later drop.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b1, 5'd2, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h50, 1'b1, 5'd2, 32'd0, 1'b0, 1'b0);
        chk("clr_pre_drop", 128'(drop_cnt_o), 128'(1));
        step(1'b1, 32'h54, 1'b1, 5'd2, 32'd0, 1'b0, 1'b1);
        chk("clr_win_ovf", 128'(overflow_o), 128'(0));
        chk("clr_win_drop", 128'(drop_cnt_o), 128'(0));
        chk("clr_keeps_fifo", 128'(count_o), 128'(16));
        step(1'b1, 32'h58, 1'b1, 5'd2, 32'd0, 1'b0, 1'b0);
        chk("post_clr_drop", 128'(drop_cnt_o), 128'(1));
        chk("post_clr_ovf", 128'(overflow_o), 128'(1));

        // Backpressure: head held for 5 cycles while more records arrive.
        do_reset();
        step(1'b1, 32'hA000, 1'b1, 5'd9, 32'h1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hB000 + 32'(i), 1'b1, 5'd4, 32'(i), 1'b0, 1'b0);
            chk($sformatf("bp%0d_head", i), 128'({out_valid, out_pc, out_ena, out_reg, out_value}),
                128'({1'b1, 32'hA000, 1'b1, 5'd9, 32'h1111}));
            commit();
        end
        drain(40);

        // Wrap: 40 records with random sink readiness.
        do_reset();
        pushed = 0;
        for (int c = 0; c < 2000 && (pushed < 40 || mq.size() != 0); c++) begin
            h = (pushed < 40) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            drive(h, 32'(4 * pushed), 1'b1, 5'd7, 32'(pushed), 1'($urandom_range(0, 1)), 1'b0);
            if (h) pushed++;
            commit();
        end
        chk("wrap_n", 128'(sink.size()), 128'(40));
        foreach (sink[i]) chk($sformatf("wrap_pc%0d", i), 128'(sink[i]), 128'(4 * i));
        chk("wrap_nodrop", 128'(drop_cnt_o), 128'(0));

        // Capture qualifier: non-writing and x0 records.
        do_reset();
        step(1'b1, 32'h40, 1'b0, 5'd3, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b1, 5'd0, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h48, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
`ifdef WB_TRACE_FILTER_EN
        chk("filt_count", 128'(count_o), 128'(1));
        chk("filt_head", 128'({out_reg, out_value}), 128'({5'd5, 32'h1234}));
`else
        chk("filt_count", 128'(count_o), 128'(3));
        chk("filt_head", 128'(out_pc), 128'(32'h40));
`endif
        drain(10);
        chk("filt_drop", 128'(drop_cnt_o), 128'(0));

        // Randomized traffic with overflow and occasional clears.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + 32'(i), 1'b1, 5'd1, 32'd0, 1'b0, 1'b0);
        chk("arst_pre_count", 128'(count_o), 128'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_count", 128'(count_o), 128'(0));
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
